exec_control_unit: RTL and testbench

//  Multi-cycle issue/execute/writeback controller directly upstream of the MIPS ALU.

---
 rtl/mips_pkg.sv | 108 ++++++++++
 rtl/reg_bank.sv | 44 ++++
 rtl/exec_control_unit.sv | 146 ++++++++++++++
 tb/tb_exec_control_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package    : mips_pkg
// Description: ALU op encoding, opcode/funct constants, controller state and
//              operand-select types, plus the instruction decode helper.
// Revision   : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int NREGS_DEF = 32;
    localparam int DW_DEF    = 32;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9,
        ALU_LUI = 4'd10
    } alu_op_t;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } ctrl_state_t;

    typedef enum logic [1:0] {
        IN1_RT   = 2'd0,
        IN1_ZIMM = 2'd1,
        IN1_SIMM = 2'd2
    } in1_sel_t;

    typedef enum logic {
        IN2_RS    = 1'b0,
        IN2_SHAMT = 1'b1
    } in2_sel_t;

    typedef struct packed {
        logic     legal;
        alu_op_t  op;
        in1_sel_t in1_sel;
        in2_sel_t in2_sel;
        logic     dest_rd;
    } dec_t;

    function automatic dec_t decode_instr(input logic [31:0] ins);
        dec_t d;
        d.legal   = 1'b1;
        d.op      = ALU_ADD;
        d.in1_sel = IN1_RT;
        d.in2_sel = IN2_RS;
        d.dest_rd = 1'b0;
        case (ins[31:26])
            OPC_RTYPE: begin
                d.dest_rd = 1'b1;
                case (ins[5:0])
                    FN_ADD:  d.op = ALU_ADD;
                    FN_SUB:  d.op = ALU_SUB;
                    FN_AND:  d.op = ALU_AND;
                    FN_OR:   d.op = ALU_OR;
                    FN_XOR:  d.op = ALU_XOR;
                    FN_NOR:  d.op = ALU_NOR;
                    FN_SLT:  d.op = ALU_SLT;
                    FN_SLL:  begin d.op = ALU_SLL; d.in2_sel = IN2_SHAMT; end
                    FN_SRL:  begin d.op = ALU_SRL; d.in2_sel = IN2_SHAMT; end
                    FN_SRA:  begin d.op = ALU_SRA; d.in2_sel = IN2_SHAMT; end
                    default: d.legal = 1'b0;
                endcase
            end
            OPC_ADDI: begin d.op = ALU_ADD; d.in1_sel = IN1_SIMM; end
            OPC_SLTI: begin d.op = ALU_SLT; d.in1_sel = IN1_SIMM; end
            OPC_ANDI: begin d.op = ALU_AND; d.in1_sel = IN1_ZIMM; end
            OPC_ORI:  begin d.op = ALU_OR;  d.in1_sel = IN1_ZIMM; end
            OPC_XORI: begin d.op = ALU_XOR; d.in1_sel = IN1_ZIMM; end
            OPC_LUI:  begin d.op = ALU_LUI; d.in1_sel = IN1_ZIMM; end
            default:  d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
// Module     : reg_bank
// Description: Register file with two async read ports, one sync write port
//              and a debug read port; register 0 always reads as zero.
// Revision   : 1.0 - initial release
// ============================================================================
module reg_bank #(
    parameter int NREGS = 32,
    parameter int DW    = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rs_addr,
    output logic [DW-1:0] rs_data,
    input  logic [AW-1:0] rt_addr,
    output logic [DW-1:0] rt_data,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    // Entry 0 has no storage; reads of address 0 are forced to zero.
    logic [DW-1:0] mem_q [1:NREGS-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && (wr_addr != '0)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rs_data  = (rs_addr  == '0) ? '0 : mem_q[rs_addr];
    assign rt_data  = (rt_addr  == '0) ? '0 : mem_q[rt_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/exec_control_unit.sv
`default_nettype none
// ============================================================================
// Module     : exec_control_unit
// Description: Issue/decode/execute/writeback controller feeding an external
//              combinational MIPS ALU, with an internal register bank.
// Revision   : 1.0 - initial release
// ============================================================================
module exec_control_unit
    import mips_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int DW    = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [31:0]   instr,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output alu_op_t       alu_op,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          zero_q,
    output logic          illegal,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    ctrl_state_t   state_q, state_d;
    logic [31:0]   instr_q, instr_d;
    logic [DW-1:0] in1_q, in1_d;
    logic [DW-1:0] in2_q, in2_d;
    alu_op_t       op_q, op_d;
    logic [AW-1:0] dest_q, dest_d;
    logic [DW-1:0] res_q, res_d;
    logic          zcap_q, zcap_d;
    logic          zero_d;

    logic [DW-1:0] rs_val, rt_val;
    logic [DW-1:0] imm_zext, imm_sext, shamt_zext;
    dec_t          dec;

    reg_bank #(.NREGS(NREGS), .DW(DW), .AW(AW)) u_reg_bank (
        .clk      (clk),
        .reset    (reset),
        .rs_addr  (instr_q[21 +: AW]),
        .rs_data  (rs_val),
        .rt_addr  (instr_q[16 +: AW]),
        .rt_data  (rt_val),
        .we       (wb_valid),
        .wr_addr  (dest_q),
        .wr_data  (res_q),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign dec        = decode_instr(instr_q);
    assign imm_zext   = {{(DW-16){1'b0}}, instr_q[15:0]};
    assign imm_sext   = {{(DW-16){instr_q[15]}}, instr_q[15:0]};
    assign shamt_zext = {{(DW-5){1'b0}}, instr_q[10:6]};

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        op_d    = op_q;
        dest_d  = dest_q;
        res_d   = res_q;
        zcap_d  = zcap_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Operands only change on a legal decode; an illegal word leaves them held.
                if (dec.legal) begin
                    case (dec.in1_sel)
                        IN1_ZIMM: in1_d = imm_zext;
                        IN1_SIMM: in1_d = imm_sext;
                        default:  in1_d = rt_val;
                    endcase
                    in2_d   = (dec.in2_sel == IN2_SHAMT) ? shamt_zext : rs_val;
                    op_d    = dec.op;
                    dest_d  = dec.dest_rd ? instr_q[11 +: AW] : instr_q[16 +: AW];
                    state_d = ST_EXECUTE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXECUTE: begin
                res_d   = alu_result;
                zcap_d  = alu_zero;
                state_d = ST_WRITEBACK;
            end
            default: begin
                zero_d  = zcap_q;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            op_q    <= ALU_ADD;
            dest_q  <= '0;
            res_q   <= '0;
            zcap_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            res_q   <= res_d;
            zcap_q  <= zcap_d;
            zero_q  <= zero_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign illegal     = (state_q == ST_DECODE) && !dec.legal;
    assign wb_valid    = (state_q == ST_WRITEBACK);
    assign alu_in1     = in1_q;
    assign alu_in2     = in2_q;
    assign alu_op      = op_q;
    assign wb_addr     = dest_q;
    assign wb_data     = res_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_control_unit.sv
`default_nettype none
// ============================================================================
// Module     : tb_exec_control_unit
// Description: Table-driven scoreboard bench for exec_control_unit with a
//              behavioural ALU attached to the operand outputs.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_exec_control_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_in1, alu_in2, alu_result;
    logic [3:0]  alu_op;
    logic        alu_zero;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        zero_q;
    logic        illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exec_control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .zero_q      (zero_q),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // In1 carries rt/immediate, In2 carries rs/shamt.
    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return b - a;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return ($signed(b) < $signed(a)) ? 32'd1 : 32'd0;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return $unsigned($signed(a) >>> b[4:0]);
            4'd10:   return a << 16;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_model(alu_op, alu_in1, alu_in2);
        alu_zero   = (alu_result == 32'd0);
    end

    typedef struct {
        logic [31:0] instr;
        logic        ill;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  op;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        zero;
    } vec_t;

    vec_t tbl [17];
    vec_t sb [$];

    function automatic vec_t mk(input logic [31:0] i, input logic il, input logic [31:0] a,
                                input logic [31:0] b, input logic [3:0] o, input logic [4:0] d,
                                input logic [31:0] r, input logic z);
        vec_t v;
        v.instr = i; v.ill = il; v.in1 = a; v.in2 = b;
        v.op = o; v.addr = d; v.data = r; v.zero = z;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   k;
        bit   seen;
        vec_t e;
        @(negedge clk);
        chk("ready_before", {31'd0, instr_ready}, 32'd1);
        instr       = v.instr;
        instr_valid = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        #1;
        // Garbage presented while busy must be ignored.
        instr = $urandom;
        k     = 0;
        seen  = 1'b0;
        while (!seen && k < 8) begin
            @(negedge clk);
            k++;
            if (k == 2 || (k == 1 && v.ill)) instr_valid = 1'b0;
            if (k == 2 && !v.ill) begin
                chk("alu_in1", alu_in1, v.in1);
                chk("alu_in2", alu_in2, v.in2);
                chk("alu_op", {28'd0, alu_op}, {28'd0, v.op});
            end
            if (wb_valid || illegal) seen = 1'b1;
        end
        instr_valid = 1'b0;
        chk("event_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            e = sb.pop_front();
            chk("latency", k, e.ill ? 32'd1 : 32'd3);
            chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
            chk("wb_valid", {31'd0, wb_valid}, {31'd0, !e.ill});
            if (!e.ill) begin
                chk("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
                chk("wb_data", wb_data, e.data);
            end
            @(negedge clk);
            chk("ready_after", {31'd0, instr_ready}, 32'd1);
            chk("pulse_end", {30'd0, wb_valid, illegal}, 32'd0);
            chk("zero_q", {31'd0, zero_q}, {31'd0, e.zero});
            if (!e.ill) chk("in1_held", alu_in1, e.in1);
        end
    endtask

    task automatic chk_dbg(input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk($sformatf("dbg_r%0d", a), dbg_data, exp);
    endtask

    initial begin
        int wb_seen;
        tbl[0]  = mk(32'h2001FFFF, 0, 32'hFFFFFFFF, 32'h0,        4'd0,  5'd1,  32'hFFFFFFFF, 0);
        tbl[1]  = mk(32'h34028000, 0, 32'h00008000, 32'h0,        4'd3,  5'd2,  32'h00008000, 0);
        tbl[2]  = mk(32'h00021900, 0, 32'h00008000, 32'd4,        4'd7,  5'd3,  32'h00080000, 0);
        tbl[3]  = mk(32'h00212022, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1,  5'd4,  32'h0,        1);
        tbl[4]  = mk(32'h00212820, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd0,  5'd5,  32'hFFFFFFFE, 0);
        tbl[5]  = mk(32'h20000005, 0, 32'h00000005, 32'h0,        4'd0,  5'd0,  32'h00000005, 0);
        tbl[6]  = mk(32'h8C000000, 1, 32'h0,        32'h0,        4'd0,  5'd0,  32'h0,        0);
        tbl[7]  = mk(32'h0020302A, 0, 32'h0,        32'hFFFFFFFF, 4'd6,  5'd6,  32'h1,        0);
        tbl[8]  = mk(32'h00013A03, 0, 32'hFFFFFFFF, 32'd8,        4'd9,  5'd7,  32'hFFFFFFFF, 0);
        tbl[9]  = mk(32'h00014702, 0, 32'hFFFFFFFF, 32'd28,       4'd8,  5'd8,  32'h0000000F, 0);
        tbl[10] = mk(32'h3C091234, 0, 32'h00001234, 32'h0,        4'd10, 5'd9,  32'h12340000, 0);
        tbl[11] = mk(32'h384AFFFF, 0, 32'h0000FFFF, 32'h00008000, 4'd4,  5'd10, 32'h00007FFF, 0);
        tbl[12] = mk(32'h00005827, 0, 32'h0,        32'h0,        4'd5,  5'd11, 32'hFFFFFFFF, 0);
        tbl[13] = mk(32'h00227024, 0, 32'h00008000, 32'hFFFFFFFF, 4'd2,  5'd14, 32'h00008000, 0);
        tbl[14] = mk(32'h302D00F0, 0, 32'h000000F0, 32'hFFFFFFFF, 4'd2,  5'd13, 32'h000000F0, 0);
        tbl[15] = mk(32'h00000021, 1, 32'h0,        32'h0,        4'd0,  5'd0,  32'h0,        0);
        tbl[16] = mk(32'h282CFFFE, 0, 32'hFFFFFFFE, 32'hFFFFFFFF, 4'd6,  5'd12, 32'h0,        1);

        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        dbg_addr    = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_in1", alu_in1, 32'd0);
        chk("rst_in2", alu_in2, 32'd0);
        chk("rst_op", {28'd0, alu_op}, 32'd0);
        chk("rst_flags", {29'd0, wb_valid, illegal, zero_q}, 32'd0);
        chk("rst_wb", {wb_data[26:0], wb_addr}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_vec(tbl[i]);
            if (i == 5) chk_dbg(5'd0, 32'd0);
        end
        chk_dbg(5'd1, 32'hFFFFFFFF);
        chk_dbg(5'd3, 32'h00080000);
        chk_dbg(5'd5, 32'hFFFFFFFE);
        chk_dbg(5'd9, 32'h12340000);
        chk_dbg(5'd12, 32'h0);

        // Reset while in EXECUTE: ADD $15,$1,$1 must never write back.
        @(negedge clk);
        instr       = 32'h00217820;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_op", {28'd0, alu_op}, 32'd0);
        reset = 1'b1;
        #1;
        chk("arst_in1", alu_in1, 32'd0);
        chk("arst_zero", {31'd0, zero_q}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("arst_ready", {31'd0, instr_ready}, 32'd1);
        chk("arst_wb", {wb_data[26:0], wb_addr}, 32'd0);
        wb_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (wb_valid || illegal) wb_seen++;
        end
        chk("arst_no_pulse", wb_seen, 32'd0);
        chk_dbg(5'd15, 32'd0);
        chk_dbg(5'd1, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
